// File: rtl/frame_cmd_scheduler.sv
// Command frame sequencer and TX arbiter: executes register read/write frames and queues responses/echoes for the shared transmitter.
// Optional saturating drop counter (drop_count/drop_clr) enabled by FRAME_CMD_DROP_COUNT_EN.
module frame_cmd_scheduler #(
    parameter int unsigned QDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       debug,
    input  logic       frame_valid,
    input  logic [8:0] frame,
    input  logic [3:0] reg_rdata,
    output logic [3:0] reg_addr,
    output logic [3:0] reg_wdata,
    output logic       reg_we,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [8:0] tx_data,
    output logic       cmd_drop,
`ifdef FRAME_CMD_DROP_COUNT_EN
    input  logic       drop_clr,
    output logic [7:0] drop_count,
`endif
    output logic       busy
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, CAPTURE} cmd_state_t;
    typedef enum logic [1:0] {T_IDLE, T_HOLD, T_WAIT} tx_state_t;

    cmd_state_t     cmd_state, cmd_state_n;
    tx_state_t      tx_state, tx_state_n;
    logic [8:0]     frame_q, frame_q_n;
    logic           dbg_q, dbg_q_n;
    logic [3:0]     reg_addr_n, reg_wdata_n;
    logic           reg_we_n, cmd_drop_n, busy_n;
    logic           tx_start_n;
    logic [8:0]     tx_data_n;

    logic [8:0]     mem [QDEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, pop;
    logic [8:0]     push_data;
    logic [1:0]     need;
    logic           room_ok;

    // Entries a frame will push: one per echo, one per read response
    always_comb begin
        need    = 2'(frame[8]) + 2'(debug);
        room_ok = (CW'(QDEPTH) - count) >= CW'(need);
    end

    // Command FSM: next state and registered-output next values
    always_comb begin
        cmd_state_n = cmd_state;
        frame_q_n   = frame_q;
        dbg_q_n     = dbg_q;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_we_n    = 1'b0;
        cmd_drop_n  = 1'b0;
        push        = 1'b0;
        push_data   = frame_q;
        case (cmd_state)
            IDLE: begin
                if (frame_valid) begin
                    frame_q_n = frame;
                    dbg_q_n   = debug;
                    if (room_ok) begin
                        cmd_state_n = EXEC;
                        reg_addr_n  = frame[7:4];
                        if (!frame[8]) begin
                            reg_we_n    = 1'b1;
                            reg_wdata_n = frame[3:0];
                        end
                    end else begin
                        cmd_drop_n = 1'b1;
                    end
                end
            end
            EXEC: begin
                push        = dbg_q;
                cmd_state_n = frame_q[8] ? CAPTURE : IDLE;
                cmd_drop_n  = frame_valid;
            end
            CAPTURE: begin
                push        = 1'b1;
                push_data   = {1'b1, frame_q[7:4], reg_rdata};
                cmd_state_n = IDLE;
                cmd_drop_n  = frame_valid;
            end
            default: cmd_state_n = IDLE;
        endcase
        busy_n = (cmd_state_n != IDLE);
    end

    // TX FSM: launch head entry, wait one cycle for busy to rise, then for it to fall
    always_comb begin
        tx_state_n = tx_state;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        pop        = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if ((count != CW'(0)) && !tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_data_n  = mem[rd_ptr];
                    pop        = 1'b1;
                    tx_state_n = T_HOLD;
                end
            end
            T_HOLD:  tx_state_n = T_WAIT;
            T_WAIT:  if (!tx_busy) tx_state_n = T_IDLE;
            default: tx_state_n = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_state <= IDLE;
            tx_state  <= T_IDLE;
            frame_q   <= 9'd0;
            dbg_q     <= 1'b0;
            reg_addr  <= 4'd0;
            reg_wdata <= 4'd0;
            reg_we    <= 1'b0;
            cmd_drop  <= 1'b0;
            busy      <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 9'd0;
        end else begin
            cmd_state <= cmd_state_n;
            tx_state  <= tx_state_n;
            frame_q   <= frame_q_n;
            dbg_q     <= dbg_q_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= reg_we_n;
            cmd_drop  <= cmd_drop_n;
            busy      <= busy_n;
            tx_start  <= tx_start_n;
            tx_data   <= tx_data_n;
        end
    end

    // TX queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            count  <= CW'(0);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

`ifdef FRAME_CMD_DROP_COUNT_EN
    // Saturating drop counter; a clear coinciding with a drop leaves one
    always_ff @(posedge clk) begin
        if (rst)
            drop_count <= 8'd0;
        else if (drop_clr)
            drop_count <= cmd_drop ? 8'd1 : 8'd0;
        else if (cmd_drop && (drop_count != 8'hFF))
            drop_count <= drop_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Testbench for frame_cmd_scheduler: directed scenarios plus random traffic against a transaction-level model.
module tb_frame_cmd_scheduler;

    localparam int unsigned QDEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, debug, frame_valid, tx_busy;
    logic [8:0] frame;
    logic [3:0] reg_rdata, reg_addr, reg_wdata;
    logic       reg_we, tx_start, cmd_drop, busy;
    logic [8:0] tx_data;
`ifdef FRAME_CMD_DROP_COUNT_EN
    logic       drop_clr = 1'b0;
    logic [7:0] drop_count;
`endif

    frame_cmd_scheduler #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .debug(debug), .frame_valid(frame_valid), .frame(frame),
        .reg_rdata(reg_rdata), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .cmd_drop(cmd_drop),
`ifdef FRAME_CMD_DROP_COUNT_EN
        .drop_clr(drop_clr), .drop_count(drop_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file stand-in: registered read, write on strobe
    logic [3:0] regs [16];
    always @(posedge clk) begin
        reg_rdata <= regs[reg_addr];
        if (reg_we) regs[reg_addr] <= reg_wdata;
    end

    // Transmitter stand-in: busy from the cycle after tx_start for a random length
    int   bcnt = 0;
    int   busy_max = 3;
    logic hold_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_start === 1'b1) bcnt <= $urandom_range(1, busy_max);
        else if (bcnt > 0)     bcnt <= bcnt - 1;
    end
    assign tx_busy = hold_busy || (bcnt != 0);

    // Reference model state
    typedef struct { logic [8:0] data; int enter; } exp_t;
    exp_t       exp_q[$];
    logic [3:0] mregs [16];
    bit         exp_drop [int];
    logic [7:0] exp_we [int];
    int         cyc = 0, acc_cyc = -100, cmd_free_at = 0, last_start = -100;
    int         drops_seen = 0;
    logic       busy_prev = 1'b0;
    int         n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int q_count(input int k);
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].enter <= k) n++;
        return n;
    endfunction

    // Accept/drop decision and consequences of a frame offered in cycle cyc
    task automatic model_frame(input logic [8:0] fr, input logic dbg);
        int need, k;
        k    = cyc;
        need = int'(fr[8]) + int'(dbg);
        if (k < cmd_free_at || int'(QDEPTH) - q_count(k) < need) begin
            exp_drop[k+1] = 1'b1;
        end else begin
            acc_cyc     = k;
            cmd_free_at = k + (fr[8] ? 3 : 2);
            if (!fr[8]) begin
                exp_we[k+1]     = fr[7:0];
                mregs[fr[7:4]]  = fr[3:0];
            end
            if (dbg)   exp_q.push_back('{data: fr, enter: k + 2});
            if (fr[8]) exp_q.push_back('{data: {1'b1, fr[7:4], mregs[fr[7:4]]}, enter: k + 3});
        end
    endtask

    task automatic check_outputs();
        int k;
        k = cyc;
        check("cmd_drop", 32'(cmd_drop), 32'(exp_drop.exists(k)));
        check("reg_we", 32'(reg_we), 32'(exp_we.exists(k)));
        if (exp_we.exists(k)) check("reg_wr_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_we[k]));
        check("busy", 32'(busy), 32'(k > acc_cyc && k < cmd_free_at));
        if (cmd_drop === 1'b1) drops_seen++;
        if (exp_q.size() == 0) begin
            check("tx_spurious", 32'(tx_start), 32'(0));
        end else if (tx_start === 1'b1) begin
            check("tx_ready", 32'(exp_q[0].enter < k), 32'(1));
            check("tx_data", 32'(tx_data), 32'(exp_q[0].data));
            check("tx_gap", 32'(k - last_start >= 3), 32'(1));
            check("tx_while_busy", 32'(busy_prev), 32'(0));
            void'(exp_q.pop_front());
            last_start = k;
        end
    endtask

    task automatic cycle(input logic fv, input logic [8:0] fr, input logic dbg);
        frame_valid = fv;
        frame       = fr;
        debug       = dbg;
        if (fv) model_frame(fr, dbg);
        busy_prev = hold_busy || (bcnt != 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 9'h000, 1'b0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_valid = 1'b0;
        frame       = 9'h000;
        debug       = 1'b0;
        busy_prev   = hold_busy || (bcnt != 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("rst_reg_we", 32'(reg_we), 32'(0));
        check("rst_reg_addr", 32'(reg_addr), 32'(0));
        check("rst_reg_wdata", 32'(reg_wdata), 32'(0));
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_cmd_drop", 32'(cmd_drop), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        exp_q.delete();
        exp_drop.delete();
        exp_we.delete();
        acc_cyc     = -100;
        cmd_free_at = 0;
        last_start  = -100;
    endtask

    initial begin
        int t0, d0;
        rst = 1'b1; frame_valid = 1'b0; frame = 9'h000; debug = 1'b0;
        for (int i = 0; i < 16; i++) begin
            regs[i]  = 4'($urandom);
            mregs[i] = regs[i];
        end
        do_reset();

        // Plain write
        cycle(1'b1, 9'b0_0011_1010, 1'b0);
        idle(6);

        // Write with echo; echo launches three cycles after the frame
        t0 = cyc;
        cycle(1'b1, 9'b0_1010_1010, 1'b1);
        idle(8);
        check("echo_latency", 32'(last_start - t0), 32'(3));

        // Read with echo after setting reg[5]=6
        cycle(1'b1, 9'b0_0101_0110, 1'b0);
        idle(4);
        cycle(1'b1, 9'b1_0101_0011, 1'b1);
        idle(20);

        // Queue full: fifth read dropped while transmitter held busy
        hold_busy = 1'b1;
        d0 = drops_seen;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, {1'b1, 4'(i + 2), 4'(i)}, 1'b0);
            idle(3);
        end
        check("qfull_drops", 32'(drops_seen - d0), 32'(1));
        hold_busy = 1'b0;
        idle(40);

        // Back-to-back frames: second dropped
        d0 = drops_seen;
        cycle(1'b1, 9'b0_0110_0001, 1'b0);
        cycle(1'b1, 9'b0_0111_0010, 1'b0);
        idle(5);
        check("b2b_drops", 32'(drops_seen - d0), 32'(1));

        // Reset while in CAPTURE with two entries queued
        hold_busy = 1'b1;
        cycle(1'b1, 9'b0_0001_0111, 1'b1);
        idle(1);
        cycle(1'b1, 9'b1_0001_0000, 1'b1);
        idle(1);
        do_reset();
        hold_busy = 1'b0;
        idle(10);
        cycle(1'b1, 9'b0_0100_1001, 1'b0);
        idle(4);

        // Random traffic with occasional long transmitter stalls
        busy_max = 5;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 3) hold_busy = ~hold_busy;
            cycle(1'($urandom_range(0, 99) < 35), 9'($urandom), 1'($urandom));
        end
        hold_busy = 1'b0;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1);
        check("drain", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_cmd_scheduler.md
Name: frame_cmd_scheduler

Overview:
- Sequences decoded 9-bit command frames from the serial receive path into the 16-entry configuration register file.
- Schedules all outgoing frames onto the single shared transmitter: read responses, plus debug echoes when `debug` is high.
- Sits between the receiver's frame/frame_valid outputs, the register file and the transmitter, and replaces ad-hoc per-source TX driving.

Parameters:
- QDEPTH, 4, TX queue depth in 9-bit entries; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- debug  in  1  level; 1 = echo every accepted frame to TX
- frame_valid  in  1  one-cycle strobe, frame is valid
- frame  in  9  {rw, addr[3:0], data[3:0]}; rw=1 read, rw=0 write
- reg_rdata  in  4  register file read data; registered, valid 1 cycle after reg_addr
- reg_addr  out  4  register address
- reg_wdata  out  4  register write data
- reg_we  out  1  one-cycle write strobe
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start
- tx_start  out  1  one-cycle launch strobe
- tx_data  out  9  frame to send; held stable while tx_start high
- cmd_drop  out  1  one-cycle pulse, frame rejected
- busy  out  1  1 when command FSM not in IDLE

Behaviour:
- Reset state: all outputs 0, queue empty, both FSMs idle.
- Reset mid-operation: pending command and queue are discarded. The transmitter is not aborted.
- Entries needed per command (N):
  - write, debug=0: N=0
  - write, debug=1: N=1
  - read, debug=0: N=1
  - read, debug=1: N=2
- `debug` is sampled on the frame_valid cycle.

Command FSM:
- IDLE
  - On frame_valid, latch frame and debug.
  - If free entries ≥ N, go to EXEC.
  - Otherwise pulse cmd_drop next cycle and stay in IDLE. No register write, no enqueue.
  - Free entries = QDEPTH − count, using count before that cycle's pop (conservative).
- EXEC (1 cycle)
  - reg_addr = addr.
  - Write: reg_wdata = data, reg_we = 1.
  - If debug: push echo = latched frame unchanged.
  - Write goes to IDLE; read goes to CAPTURE.
- CAPTURE (1 cycle)
  - Push response {1'b1, addr, reg_rdata}, then go to IDLE.
- frame_valid while not IDLE: frame dropped, cmd_drop pulses next cycle, FSM unaffected.
- Latencies after the frame_valid edge:
  - reg_we asserted in cycle +1.
  - Echo present in queue from cycle +2.
  - Response present in queue from cycle +3.
- Echo always precedes the response of the same read.

TX queue and TX FSM:
- Queue: FIFO, at most one push per cycle. Push and pop in the same cycle are allowed; count is unchanged.
- Pointers wrap modulo QDEPTH. Count width is log2(QDEPTH)+1.
- The room check guarantees the queue never overflows.
- TX FSM states:
  - T_IDLE: if queue non-empty and !tx_busy, drive tx_data = head, tx_start = 1, pop, go to T_HOLD.
  - T_HOLD: 1 cycle; ignores tx_busy (transmitter has not yet asserted it). Go to T_WAIT.
  - T_WAIT: stay until tx_busy = 0, then T_IDLE.
- Minimum spacing between tx_start pulses is 3 cycles.
- tx_data holds its last value when not starting.

Optional Feature:
- Macro: FRAME_CMD_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count[7:0]: saturating count of cmd_drop pulses (holds at 255). Reset to 0.
  - Adds input drop_clr: synchronous clear. If drop_clr and cmd_drop occur in the same cycle, the result is 1.
- Undefined: neither port exists. Behaviour is otherwise identical.

Test Plan:
- Write, debug=0: frame=9'b0_0011_1010 → reg_we 1 cycle at +1 with reg_addr=3, reg_wdata=4'hA. No tx_start.
- Write, debug=1: frame=9'b0_1010_1010 → reg_we at +1. tx_start at +3 with tx_data=9'b010101010.
- Read, debug=1, reg[5]=4'h6: frame=9'b1_0101_0011 → echo 9'b101010011 sent first. After tx_busy falls, response 9'b1_0101_0110 sent.
- Queue full, QDEPTH=4, tx_busy held 1: five reads with debug=0 spaced 4 cycles apart → first four queued, fifth pulses cmd_drop. Release tx_busy → four responses sent in order.
- Back-to-back: frame_valid on two consecutive cycles → second dropped (cmd_drop), first completes normally.
- Reset in CAPTURE with 2 queued entries → all outputs 0, no tx_start after reset, next write executes normally.
